sprite_line_scheduler: RTL and testbench

- Per-scanline sprite evaluator for the video pipeline.
- On each line_start pulse it scans object attribute memory (OAM: 64-bit entries, same layout the sprite renderer decodes) for sprites that intersect the next scanline.
- It copies up to SLOTS hits, in OAM index order, into the line-slot register file that feeds the per-slot sprite renderers.
- It reports the hit count and an overflow flag.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_row_hit.sv | 23 ++
 rtl/sprite_line_scheduler.sv | 118 +++++++++++
 tb/tb_sprite_line_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: OAM field layout, sprite geometry and
// scheduler state encoding.
package sprite_pkg;

  localparam int SPR_W = 8;
  localparam int SPR_H = 8;

  localparam int Y_LO         = 0;
  localparam int Y_HI         = 10;
  localparam int X_LO         = 11;
  localparam int X_HI         = 21;
  localparam int ROTSCALE_BIT = 22;
  localparam int DISABLE_BIT  = 23;
  localparam int NAME_LO      = 36;
  localparam int NAME_HI      = 43;
  localparam int PAL_LO       = 44;
  localparam int PAL_HI       = 47;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } sched_state_e;

endpackage

// File: rtl/sprite_row_hit.sv
// Combinational row test: does this OAM entry cover scanline i_y?
// The Y subtraction wraps mod 2^11 so sprites straddle line 0.
module sprite_row_hit
  import sprite_pkg::*;
#(
  parameter int H = 8
) (
  input  logic [63:0] i_attr,
  input  logic [10:0] i_y,
  output logic        o_hit
);

  logic        w_en;
  logic [10:0] w_dy;
  logic        w_unused;

  assign w_en  = i_attr[ROTSCALE_BIT] | ~i_attr[DISABLE_BIT];
  assign w_dy  = i_y - i_attr[Y_HI:Y_LO];
  assign o_hit = w_en & (w_dy < 11'(H));

  assign w_unused = ^{i_attr[63:24], i_attr[X_HI:X_LO]};

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline OAM scan: copies up to SLOTS visible sprites, in index
// order, into the line-slot file and flags overflow.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 128,
  parameter int SLOTS       = 8,
  parameter int SPR_H       = 8,
  localparam int AW = $clog2(NUM_SPRITES),
  localparam int CW = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [10:0]   next_y,
  output logic          oam_rd,
  output logic [AW-1:0] oam_addr,
  input  logic [63:0]   oam_data,
  output logic          slot_we,
  output logic [CW-1:0] slot_idx,
  output logic [63:0]   slot_attr,
  output logic [CW:0]   slot_count,
  output logic          overflow,
  output logic          busy,
  output logic          done
);

  sched_state_e r_state, w_state_nx;

  logic [10:0]   r_y;
  logic [AW-1:0] r_idx;
  logic          r_rd_valid;
  logic [CW:0]   r_count;
  logic          r_ovf;
  logic          r_done;

  logic w_hit, w_eval, w_full, w_wr;
  logic w_ovf_hit, w_last, w_done_nx;

  sprite_row_hit #(.H(SPR_H)) u_hit (
    .i_attr (oam_data),
    .i_y    (r_y),
    .o_hit  (w_hit)
  );

  // A restart in the same cycle discards the returning word.
  assign w_eval    = r_rd_valid & ~line_start;
  assign w_full    = (r_count == (CW+1)'(SLOTS));
  assign w_wr      = w_eval & w_hit & ~w_full;
  assign w_ovf_hit = w_eval & w_hit & w_full;
  assign w_last    = (r_idx == AW'(NUM_SPRITES - 1));

  always_comb begin
    w_state_nx = r_state;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (line_start) w_state_nx = SCAN;
      end
      SCAN: begin
        if (line_start) begin
          w_state_nx = SCAN;
        end else if (w_ovf_hit) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end else if (w_last) begin
          w_state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (line_start) begin
          w_state_nx = SCAN;
        end else begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign oam_rd     = (r_state == SCAN) & ~w_ovf_hit;
  assign oam_addr   = r_idx;
  assign slot_we    = w_wr;
  assign slot_idx   = r_count[CW-1:0];
  assign slot_attr  = oam_data;
  assign slot_count = r_count;
  assign overflow   = r_ovf;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_y        <= '0;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_done     <= w_done_nx;
      r_rd_valid <= oam_rd & ~line_start;
      if (line_start) begin
        r_y     <= next_y;
        r_idx   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (r_state == SCAN && !w_last) r_idx <= r_idx + 1'b1;
        if (w_wr) r_count <= r_count + 1'b1;
        if (w_ovf_hit) r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: directed OAM images,
// expected slot writes queued, a negedge monitor compares.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [10:0] next_y;
  logic        oam_rd;
  logic [6:0]  oam_addr;
  logic [63:0] oam_data;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [63:0] slot_attr;
  logic [3:0]  slot_count;
  logic        overflow;
  logic        busy;
  logic        done;

  sprite_line_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .next_y     (next_y),
    .oam_rd     (oam_rd),
    .oam_addr   (oam_addr),
    .oam_data   (oam_data),
    .slot_we    (slot_we),
    .slot_idx   (slot_idx),
    .slot_attr  (slot_attr),
    .slot_count (slot_count),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] attr;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem [128];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cnt = 0;
  int rd8_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (oam_rd) oam_data <= mem[oam_addr];
  end

  always @(negedge clk) begin
    if (slot_we) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL slot_write_unexpected: got idx=%0d attr=%h, want none",
                 slot_idx, slot_attr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (slot_idx !== e.idx || slot_attr !== e.attr) begin
          bad++;
          $display("FAIL slot_write: got idx=%0d attr=%h, want idx=%0d attr=%h",
                   slot_idx, slot_attr, e.idx, e.attr);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (oam_rd) begin
      rd_cnt++;
      if (oam_addr == 7'd8) rd8_cyc = cyc;
    end
  end

  function automatic logic [63:0] mk(int i, logic [10:0] y,
                                     logic rs, logic dis);
    return {16'(i * 7 + 1), 16'hBEEF, 8'h00, dis, rs, 11'(i), y};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 128; i++) mem[i] = mk(i, 11'd0, 1'b0, 1'b1);
  endtask

  task automatic expect_slot(input int s, input int e);
    q.push_back({3'(s), mem[e]});
  endtask

  task automatic start(input logic [10:0] y);
    @(posedge clk); #1;
    line_start = 1'b1;
    next_y     = y;
    t0         = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic finish_line(input string tag, input int d0, input int cnt,
                             input logic ovf, input bit full_scan);
    wait_done(d0);
    if (full_scan) check({tag, "_latency"}, 64'(done_cyc - t0), 64'd130);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(slot_count), 64'(cnt));
    check({tag, "_ovf"}, 64'(overflow), 64'(ovf));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pending"}, 64'(q.size()), 64'd0);
    check({tag, "_one_done"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    int r0;
    reset      = 1'b1;
    line_start = 1'b0;
    next_y     = '0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(slot_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_rd", 64'(oam_rd), 64'd0);
    check("rst_addr", 64'(oam_addr), 64'd0);
    reset = 1'b0;

    // two visible sprites, last row of each
    mem[3]   = mk(3, 11'd50, 1'b0, 1'b0);
    mem[100] = mk(100, 11'd50, 1'b0, 1'b0);
    expect_slot(0, 3);
    expect_slot(1, 100);
    d0 = done_cnt;
    start(11'd57);
    finish_line("vis", d0, 2, 1'b0, 1'b1);

    d0 = done_cnt;
    start(11'd58);
    finish_line("miss", d0, 0, 1'b0, 1'b1);

    // overflow: ten sprites on line 0
    clear_oam();
    for (int i = 0; i < 10; i++) mem[i] = mk(i, 11'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) expect_slot(i, i);
    d0 = done_cnt;
    r0 = rd_cnt;
    start(11'd0);
    finish_line("ovf", d0, 8, 1'b1, 1'b0);
    check("ovf_done_gap_ok", 64'((done_cyc - (rd8_cyc + 1)) inside {[1:2]}), 64'd1);
    check("ovf_reads", 64'(rd_cnt - r0), 64'd9);

    // wrap-around and rotscale override
    clear_oam();
    mem[5] = mk(5, 11'd2046, 1'b0, 1'b0);
    mem[7] = mk(7, 11'd100, 1'b1, 1'b1);
    expect_slot(0, 5);
    d0 = done_cnt;
    start(11'd3);
    finish_line("wrap3", d0, 1, 1'b0, 1'b1);
    d0 = done_cnt;
    start(11'd6);
    finish_line("wrap6", d0, 0, 1'b0, 1'b1);
    expect_slot(0, 5);
    d0 = done_cnt;
    start(11'd2047);
    finish_line("wrap2047", d0, 1, 1'b0, 1'b1);
    expect_slot(0, 7);
    d0 = done_cnt;
    start(11'd100);
    finish_line("rotscale", d0, 1, 1'b0, 1'b1);

    // restart mid-scan: entry 3 already written before the restart
    clear_oam();
    mem[3]   = mk(3, 11'd50, 1'b0, 1'b0);
    mem[20]  = mk(20, 11'd5, 1'b0, 1'b0);
    mem[100] = mk(100, 11'd50, 1'b0, 1'b0);
    expect_slot(0, 3);
    expect_slot(0, 20);
    d0 = done_cnt;
    start(11'd57);
    repeat (38) @(posedge clk);
    start(11'd10);
    finish_line("restart", d0, 1, 1'b0, 1'b1);

    // reset mid-scan
    expect_slot(0, 3);
    d0 = done_cnt;
    start(11'd57);
    repeat (18) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_count", 64'(slot_count), 64'd0);
    check("midrst_rd", 64'(oam_rd), 64'd0);
    r0 = rd_cnt;
    repeat (150) @(posedge clk);
    #1;
    check("midrst_no_rd", 64'(rd_cnt - r0), 64'd0);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    check("midrst_pending", 64'(q.size()), 64'd0);

    // line_start together with reset: reset wins
    @(posedge clk); #1;
    reset      = 1'b1;
    line_start = 1'b1;
    next_y     = 11'd57;
    @(posedge clk); #1;
    reset      = 1'b0;
    line_start = 1'b0;
    check("rst_wins_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_wins_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
